// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens and decoder alignment state.
// No logic; constants only.
// No flow control.
package tmds_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } tmds_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Maps one aligned 10-bit TMDS symbol to pixel data or a control pair.
// Latency: combinational.
// Backpressure: none.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] w,
    output logic [7:0] dout,
    output logic       c1,
    output logic       c0,
    output logic       is_token
);

    logic [7:0] d;

    always_comb begin
        d        = w[9] ? ~w[7:0] : w[7:0];
        dout     = '0;
        c1       = 1'b0;
        c0       = 1'b0;
        is_token = 1'b1;
        unique case (w)
            TMDS_CTRL_00: {c1, c0} = 2'b00;
            TMDS_CTRL_01: {c1, c0} = 2'b01;
            TMDS_CTRL_10: {c1, c0} = 2'b10;
            TMDS_CTRL_11: {c1, c0} = 2'b11;
            default: begin
                is_token = 1'b0;
                // w[8] selects XOR vs XNOR chaining used by the encoder
                dout[0] = d[0];
                for (int i = 1; i < 8; i++) begin
                    dout[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
                end
            end
        endcase
    end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel receiver: finds the symbol boundary via control-token runs, then decodes.
// Latency: 1 clk from accepted raw_in to out_valid; symbol window spans previous+current word.
// Backpressure: none; raw_valid=0 cycles freeze all state and drop out_valid.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int TOKEN_RUN      = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] raw_in,
    input  logic       raw_valid,
    output logic [7:0] dout,
    output logic       c0,
    output logic       c1,
    output logic       blanking,
    output logic       out_valid,
    output logic       locked,
    output logic [3:0] bit_offset
);

    localparam int RUN_W    = $clog2(TOKEN_RUN + 1);
    localparam int IDLE_MAX = (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

    tmds_state_t       state;
    logic [3:0]        offset;
    logic [RUN_W-1:0]  run_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [9:0]        prev;

    logic [19:0]       shifted;
    logic [9:0]        w;
    logic [7:0]        sym_dout;
    logic              sym_c1;
    logic              sym_c0;
    logic              is_token;
    logic [RUN_W-1:0]  run_inc;
    logic [IDLE_W-1:0] idle_inc;

    assign shifted  = {raw_in, prev} >> offset;
    assign w        = shifted[9:0];
    assign run_inc  = (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
    assign idle_inc = (idle_cnt == '1) ? idle_cnt : idle_cnt + 1'b1;

    tmds_symbol_decode u_sym (
        .w        (w),
        .dout     (sym_dout),
        .c1       (sym_c1),
        .c0       (sym_c0),
        .is_token (is_token)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SEARCH;
            offset    <= '0;
            run_cnt   <= '0;
            idle_cnt  <= '0;
            prev      <= '0;
            dout      <= '0;
            c0        <= 1'b0;
            c1        <= 1'b0;
            blanking  <= 1'b0;
            out_valid <= 1'b0;
        end else if (raw_valid) begin
            prev      <= raw_in;
            out_valid <= (state == LOCKED);
            if (state == LOCKED) begin
                dout     <= sym_dout;
                c1       <= sym_c1;
                c0       <= sym_c0;
                blanking <= is_token;
            end
            case (state)
                SEARCH: begin
                    if (is_token) begin
                        idle_cnt <= '0;
                        if (run_inc == RUN_W'(TOKEN_RUN)) begin
                            state   <= LOCKED;
                            run_cnt <= '0;
                        end else begin
                            run_cnt <= run_inc;
                        end
                    end else begin
                        run_cnt <= '0;
                        if (idle_inc == IDLE_W'(SEARCH_TIMEOUT)) begin
                            offset   <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_inc;
                        end
                    end
                end
                LOCKED: begin
                    // A token always wins over a coincident timeout
                    if (is_token) begin
                        idle_cnt <= '0;
                    end else if (idle_inc == IDLE_W'(LOCK_TIMEOUT)) begin
                        state    <= SEARCH;
                        run_cnt  <= '0;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_inc;
                    end
                end
            endcase
        end else begin
            out_valid <= 1'b0;
        end
    end

    assign locked     = (state == LOCKED);
    assign bit_offset = offset;

endmodule
